// File: rtl/op_sequencer_if.sv
// Command, serial write/read and controller-facing signals of the op sequencer.
// The master side is the host that pushes commands and models the controller;
// the slave side is the sequencer itself.
interface op_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;

    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;

    logic        rdata_valid;
    logic [31:0] rdata;

    logic        ctrl_enable;
    logic [31:0] ctrl_operation;
    logic [31:0] ctrl_in_data;
    logic [31:0] ctrl_out_data;

    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output cmd_valid, cmd_data, wdata_valid, wdata, ctrl_out_data,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, ctrl_enable,
               ctrl_operation, ctrl_in_data, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_data, wdata_valid, wdata, ctrl_out_data,
        output cmd_ready, wdata_ready, rdata_valid, rdata, ctrl_enable,
               ctrl_operation, ctrl_in_data, busy, done, err
    );

endinterface

// File: rtl/op_sequencer.sv
// Command front-end for the matrix controller. Queues 32-bit command words and
// replays them as a timed operation stream: op 1 held for MULT_CYCLES, op 2
// streams a page of write words into the controller, op 3 collects a page of
// read words back onto rdata. Every command ends with a one-cycle zero gap.
module op_sequencer #(
    parameter int unsigned CMD_DEPTH   = 4,
    parameter int unsigned PAGE_WORDS  = 64,
    parameter int unsigned MULT_CYCLES = 48,
    parameter int unsigned READ_LAT    = 1
) (
    input logic           clk,
    input logic           reset,
    input logic           enable,
    op_sequencer_if.slave bus
);

    localparam int unsigned PtrW   = $clog2(CMD_DEPTH);
    localparam int unsigned CntMax = (MULT_CYCLES > PAGE_WORDS) ? MULT_CYCLES : PAGE_WORDS;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] MultLast = CntW'(MULT_CYCLES - 1);
    localparam logic [CntW-1:0] PageLast = CntW'(PAGE_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StMult, StWrite, StRead, StGap} state_e;

    state_e              state_q, state_d;
    logic [31:0]         fifo_mem [CMD_DEPTH];
    logic [PtrW:0]       wr_ptr_q, rd_ptr_q;
    logic                fifo_empty, fifo_full;
    logic                push, pop;
    logic [31:0]         head;
    logic [3:0]          head_op;
    logic [31:0]         op_q, op_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     rcv_q, rcv_d;
    logic                issued_all_q, issued_all_d;
    logic [READ_LAT-1:0] tag_q, tag_d;
    logic                tag_out;
    logic                issue;
    logic [31:0]         rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ctrl_en;
    logic                wready;

    // FIFO status; the extra pointer bit separates full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push       = bus.cmd_valid & bus.cmd_ready;
    assign head       = fifo_mem[rd_ptr_q[PtrW-1:0]];
    assign head_op    = head[3:0];
    assign tag_out    = tag_q[READ_LAT-1];

    // Command storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PtrW-1:0]] <= bus.cmd_data;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            end
        end
    end

    // Read tag pipe: one bit per issued op-3 cycle, advancing only when enabled.
    always_comb begin
        tag_d = tag_q;
        if (enable) begin
            tag_d[0] = issue;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Sequencer next state, counters and controller-facing strobes.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        rcv_d         = rcv_q;
        issued_all_d  = issued_all_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        pop           = 1'b0;
        issue         = 1'b0;
        ctrl_en       = 1'b0;
        wready        = 1'b0;

        if (enable) begin
            unique case (state_q)
                // GAP also dispatches the next command so back-to-back
                // commands are separated by exactly one zero cycle.
                StIdle, StGap: begin
                    op_d    = '0;
                    state_d = StIdle;
                    if (state_q == StGap) begin
                        ctrl_en = 1'b1;
                    end
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        cnt_d        = '0;
                        rcv_d        = '0;
                        issued_all_d = 1'b0;
                        case (head_op)
                            4'd0: op_d = '0;
                            4'd1: begin
                                state_d = StMult;
                                op_d    = head;
                            end
                            4'd2: begin
                                state_d = StWrite;
                                op_d    = head;
                            end
                            4'd3: begin
                                state_d = StRead;
                                op_d    = head;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                StMult: begin
                    ctrl_en = 1'b1;
                    if (cnt_q == MultLast) begin
                        state_d = StGap;
                        op_d    = '0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StWrite: begin
                    if (bus.wdata_valid) begin
                        ctrl_en = 1'b1;
                        wready  = 1'b1;
                        if (cnt_q == PageLast) begin
                            state_d = StGap;
                            op_d    = '0;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StRead: begin
                    if (!issued_all_q) begin
                        ctrl_en = 1'b1;
                        issue   = 1'b1;
                        if (cnt_q == PageLast) begin
                            issued_all_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    if (tag_out) begin
                        rdata_valid_d = 1'b1;
                        rdata_d       = bus.ctrl_out_data;
                        // Leave only once the final word has been captured.
                        if (rcv_q == PageLast) begin
                            state_d = StGap;
                            op_d    = '0;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            rcv_d   = '0;
                        end else begin
                            rcv_d = rcv_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    op_d    = '0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            op_q          <= '0;
            cnt_q         <= '0;
            rcv_q         <= '0;
            issued_all_q  <= 1'b0;
            tag_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            rcv_q         <= rcv_d;
            issued_all_q  <= issued_all_d;
            tag_q         <= tag_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.cmd_ready      = enable & ~fifo_full;
    assign bus.wdata_ready    = wready;
    assign bus.ctrl_enable    = ctrl_en;
    assign bus.ctrl_operation = op_q;
    assign bus.ctrl_in_data   = (state_q == StWrite) ? bus.wdata : '0;
    assign bus.rdata          = rdata_q;
    assign bus.rdata_valid    = rdata_valid_q;
    assign bus.busy           = (state_q != StIdle) | ~fifo_empty;
    assign bus.done           = done_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: mult hold, paced page write, page read with a
// one-cycle-latency controller model, queueing/full/err, enable freeze and
// asynchronous reset mid-read. Inputs change at the falling edge and outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_op_sequencer;

    logic clk;
    logic reset;
    logic enable;
    int   n_checks;
    int   n_errors;

    op_sequencer_if bus ();

    op_sequencer #(
        .CMD_DEPTH  (4),
        .PAGE_WORDS (64),
        .MULT_CYCLES(48),
        .READ_LAT   (1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait a bounded number of cycles for ctrl_operation to show v.
    task automatic wait_op(input logic [31:0] v, input string tag);
        for (int i = 0; i < 8 && bus.ctrl_operation !== v; i++) begin
            @(negedge clk);
            #1;
        end
        check_val(tag, bus.ctrl_operation, v);
    endtask

    // Push 0x321 into an idle sequencer and check the full op-1 timeline.
    task automatic mult_cmd_check(input string tag);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0321;
        #1;
        check_val({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        check_val({tag, "_pre_op"}, bus.ctrl_operation, 32'h0);
        check_val({tag, "_pre_busy"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        check_val({tag, "_op"}, bus.ctrl_operation, 32'h321);
        n = 0;
        while (bus.ctrl_operation == 32'h321 && bus.ctrl_enable && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_val({tag, "_len"}, 32'(n), 32'd48);
        check_val({tag, "_gap_op"}, bus.ctrl_operation, 32'h0);
        check_val({tag, "_gap_en"}, 32'(bus.ctrl_enable), 32'd1);
        check_val({tag, "_gap_done"}, 32'(bus.done), 32'd1);
        @(negedge clk);
        #1;
        check_val({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        check_val({tag, "_end_done"}, 32'(bus.done), 32'd0);
        check_val({tag, "_end_en"}, 32'(bus.ctrl_enable), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int widx, dones, bad, bad_en, bad_data, iss, rx, k_prev, n, errs, ridx, zc;
        bit prev_iss, in_run;
        int run_len[3];
        int zgap[2];

        n_checks          = 0;
        n_errors          = 0;
        reset             = 1'b1;
        enable            = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_data      = '0;
        bus.wdata_valid   = 1'b0;
        bus.wdata         = '0;
        bus.ctrl_out_data = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_op", bus.ctrl_operation, 32'h0);
        check_val("rst_en", 32'(bus.ctrl_enable), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
        check_val("rst_rdata", bus.rdata, 32'h0);
        check_val("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        check_val("rst_indata", bus.ctrl_in_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: single op-1 command.
        mult_cmd_check("t1");

        // 2: page write with wdata_valid low on every 4th cycle.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0012;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        wait_op(32'h12, "t2_start");
        widx = 0; dones = 0; bad_en = 0; bad_data = 0;
        for (int c = 0; c < 200 && widx < 64; c++) begin
            if (c > 0) @(negedge clk);
            bus.wdata_valid = (c % 4 != 3);
            bus.wdata       = 32'(widx);
            #1;
            if (bus.ctrl_enable !== bus.wdata_valid || bus.wdata_ready !== bus.wdata_valid ||
                bus.ctrl_operation !== 32'h12) begin
                bad_en++;
            end
            if (bus.done) dones++;
            if (bus.wdata_valid) begin
                if (bus.ctrl_in_data !== 32'(widx)) bad_data++;
                widx++;
            end
        end
        @(negedge clk);
        bus.wdata_valid = 1'b0;
        #1;
        if (bus.done) dones++;
        check_val("t2_words", 32'(widx), 32'd64);
        check_val("t2_en_bad", 32'(bad_en), 32'd0);
        check_val("t2_data_bad", 32'(bad_data), 32'd0);
        check_val("t2_gap_op", bus.ctrl_operation, 32'h0);
        check_val("t2_gap_indata", bus.ctrl_in_data, 32'h0);
        check_val("t2_gap_wready", 32'(bus.wdata_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (bus.done) dones++;
        end
        check_val("t2_done_cnt", 32'(dones), 32'd1);
        check_val("t2_busy", 32'(bus.busy), 32'd0);

        // 3: page read; controller returns word k one cycle after issue k.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0013;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        wait_op(32'h13, "t3_start");
        iss = 0; rx = 0; bad = 0; dones = 0; prev_iss = 1'b0; k_prev = 0;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.ctrl_out_data = prev_iss ? 32'(k_prev) : 32'hdead_beef;
                #1;
            end
            if (bus.rdata_valid) begin
                if (bus.rdata !== 32'(rx)) bad++;
                rx++;
            end
            if (bus.done) dones++;
            if (bus.ctrl_enable && bus.ctrl_operation == 32'h13) begin
                prev_iss = 1'b1;
                k_prev   = iss;
                iss++;
            end else begin
                prev_iss = 1'b0;
            end
        end
        check_val("t3_issued", 32'(iss), 32'd64);
        check_val("t3_rx_cnt", 32'(rx), 32'd64);
        check_val("t3_rx_order", 32'(bad), 32'd0);
        check_val("t3_done_cnt", 32'(dones), 32'd1);
        check_val("t3_busy", 32'(bus.busy), 32'd0);

        // 4: queue 0x5, 0x0, 0x321, 0x321 behind a running op-1, then hit full.
        errs = 0; dones = 0; ridx = 0; zc = 0; in_run = 1'b0;
        run_len = '{0, 0, 0};
        zgap    = '{-1, -1};
        for (int c = 0; c < 220; c++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            case (c)
                0: begin bus.cmd_valid = 1'b1; bus.cmd_data = 32'h321; end
                5: begin bus.cmd_valid = 1'b1; bus.cmd_data = 32'h5;   end
                6: begin bus.cmd_valid = 1'b1; bus.cmd_data = 32'h0;   end
                7: begin bus.cmd_valid = 1'b1; bus.cmd_data = 32'h321; end
                8: begin bus.cmd_valid = 1'b1; bus.cmd_data = 32'h321; end
                9: begin bus.cmd_valid = 1'b1; bus.cmd_data = 32'hf;   end
                default: ;
            endcase
            #1;
            if (c == 0 || (c >= 5 && c <= 8)) begin
                check_val($sformatf("t4_ready_c%0d", c), 32'(bus.cmd_ready), 32'd1);
            end
            if (c == 9) check_val("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
            if (bus.err) errs++;
            if (bus.done) dones++;
            if (bus.ctrl_operation == 32'h321) begin
                if (!in_run) begin
                    if (ridx >= 1 && ridx <= 2) zgap[ridx-1] = zc;
                    in_run = 1'b1;
                end
                if (bus.ctrl_enable && ridx < 3) run_len[ridx]++;
            end else begin
                if (in_run) begin
                    in_run = 1'b0;
                    ridx++;
                    zc = 0;
                end
                zc++;
            end
        end
        check_val("t4_runs", 32'(ridx), 32'd3);
        check_val("t4_len0", 32'(run_len[0]), 32'd48);
        check_val("t4_len1", 32'(run_len[1]), 32'd48);
        check_val("t4_len2", 32'(run_len[2]), 32'd48);
        check_val("t4_zero_12", 32'(zgap[0]), 32'd3);
        check_val("t4_zero_23", 32'(zgap[1]), 32'd1);
        check_val("t4_err_cnt", 32'(errs), 32'd1);
        check_val("t4_done_cnt", 32'(dones), 32'd3);
        check_val("t4_busy", 32'(bus.busy), 32'd0);

        // 5: enable low for 10 cycles mid-MULT.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h321;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        wait_op(32'h321, "t5_start");
        n = 0; dones = 0; bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin
                @(negedge clk);
                enable = !(c >= 20 && c < 30);
                #1;
            end
            if (bus.ctrl_operation == 32'h321 && bus.ctrl_enable) n++;
            if (!enable && (bus.ctrl_enable || bus.ctrl_operation !== 32'h321 || bus.cmd_ready)) bad++;
            if (bus.done) dones++;
        end
        check_val("t5_len", 32'(n), 32'd48);
        check_val("t5_frozen_bad", 32'(bad), 32'd0);
        check_val("t5_done_cnt", 32'(dones), 32'd1);
        check_val("t5_busy", 32'(bus.busy), 32'd0);

        // 6: asynchronous reset mid-READ with a command still queued.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h13;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        wait_op(32'h13, "t6_start");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.ctrl_out_data = 32'(c + 100);
            bus.cmd_valid     = (c == 3);
            bus.cmd_data      = 32'h321;
        end
        #1;
        check_val("t6_pre_rdata_nz", 32'(bus.rdata != 32'h0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("t6_rst_op", bus.ctrl_operation, 32'h0);
        check_val("t6_rst_en", 32'(bus.ctrl_enable), 32'd0);
        check_val("t6_rst_busy", 32'(bus.busy), 32'd0);
        check_val("t6_rst_rdata", bus.rdata, 32'h0);
        check_val("t6_rst_rvalid", 32'(bus.rdata_valid), 32'd0);
        check_val("t6_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("t6_post_busy", 32'(bus.busy), 32'd0);
        mult_cmd_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
